// File: rtl/tcp_rx_sequencer.sv
// Receive-side TCP sequencer: validates parsed segments against the expected sequence number,
// runs a LISTEN/ESTABLISHED/DRAIN FSM and queues in-order payload words for the consumer.
// Latency: segment strobed in N -> state/FIFO/drop update end of N, ACK_REQ pulse and head valid in N+1.
// Backpressure: none on the segment input; a full payload FIFO drops the segment and re-ACKs exp_seq.
// Ports:
//   i_clk, i_rst_n                          clock, async active-low reset
//   i_packet_ready, i_seq_num, i_ack_num,
//   i_flags, i_payload_len, i_payload_data  parsed segment strobe and fields
//   o_payload_valid/data/len, i_payload_ready  first-word-fall-through payload FIFO head
//   o_ack_req, o_ack_value                  ACK request pulse and ack number
//   o_last_ack, o_conn_state, o_drop_cnt    status
module tcp_rx_sequencer #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_packet_ready,
  input  logic [7:0]  i_seq_num,
  input  logic [7:0]  i_ack_num,
  input  logic [7:0]  i_flags,
  input  logic [2:0]  i_payload_len,
  input  logic [31:0] i_payload_data,
  output logic        o_payload_valid,
  output logic [31:0] o_payload_data,
  output logic [2:0]  o_payload_len,
  input  logic        i_payload_ready,
  output logic        o_ack_req,
  output logic [7:0]  o_ack_value,
  output logic [7:0]  o_last_ack,
  output logic [1:0]  o_conn_state,
  output logic [15:0] o_drop_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    ST_LISTEN = 2'd0,
    ST_ESTAB  = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [7:0]      r_exp_seq, w_exp_nxt;
  logic [34:0]     r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            r_ack_req;
  logic [7:0]      r_ack_value, r_last_ack;
  logic [15:0]     r_drop_cnt;

  logic w_fin, w_syn, w_rst, w_ackf;
  logic w_malformed, w_full, w_empty, w_in_order, w_room, w_seg_ok, w_pop;
  logic w_push, w_flush, w_drop, w_ack, w_last_we;
  logic [7:0] w_ack_val;
  logic w_unused;

  assign w_fin  = i_flags[0];
  assign w_syn  = i_flags[1];
  assign w_rst  = i_flags[2];
  assign w_ackf = i_flags[4];
  assign w_unused = ^{i_flags[7:5], i_flags[3]};

  assign w_malformed = (i_payload_len > 3'd4) || (w_syn && w_fin);
  assign w_full      = (r_count == CW'(FIFO_DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_in_order  = (i_seq_num == r_exp_seq) && !w_syn;
  // Fullness is judged on the registered count, so a same-cycle pop never frees room.
  assign w_room      = (i_payload_len == 3'd0) || !w_full;
  assign w_seg_ok    = i_packet_ready && !w_rst && !w_malformed;
  assign w_pop       = !w_empty && i_payload_ready;

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_LISTEN;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    if (i_packet_ready && w_rst) begin
      w_state_nxt = ST_LISTEN;
    end else begin
      case (r_state)
        ST_LISTEN: if (w_seg_ok && w_syn) w_state_nxt = ST_ESTAB;
        ST_ESTAB:  if (w_seg_ok && w_in_order && w_room && w_fin) w_state_nxt = ST_DRAIN;
        ST_DRAIN:  if (w_empty) w_state_nxt = ST_LISTEN;
        default:   w_state_nxt = ST_LISTEN;
      endcase
    end
  end

  // Per-segment decisions
  always_comb begin
    w_push    = 1'b0;
    w_flush   = 1'b0;
    w_drop    = 1'b0;
    w_ack     = 1'b0;
    w_last_we = 1'b0;
    w_exp_nxt = r_exp_seq;
    w_ack_val = r_exp_seq;  // duplicate ACK value unless overridden
    if (i_packet_ready) begin
      if (w_rst) begin
        w_flush   = 1'b1;
        w_exp_nxt = 8'd0;
      end else if (w_malformed) begin
        w_drop = 1'b1;
      end else begin
        case (r_state)
          ST_LISTEN: begin
            if (w_syn) begin
              w_exp_nxt = i_seq_num + 8'd1;
              w_ack_val = i_seq_num + 8'd1;
              w_ack     = 1'b1;
            end else begin
              w_drop = 1'b1;
            end
          end
          ST_ESTAB: begin
            w_ack = 1'b1;
            if (w_in_order && w_room) begin
              w_push    = (i_payload_len != 3'd0);
              w_exp_nxt = r_exp_seq + {5'd0, i_payload_len} + {7'd0, w_fin};
              w_ack_val = w_exp_nxt;
              w_last_we = w_ackf;
            end else begin
              w_drop = 1'b1;
            end
          end
          default: w_drop = 1'b1;
        endcase
      end
    end
  end

  // Sequencer registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_exp_seq   <= 8'd0;
      r_ack_req   <= 1'b0;
      r_ack_value <= 8'd0;
      r_last_ack  <= 8'd0;
      r_drop_cnt  <= 16'd0;
    end else begin
      r_exp_seq <= w_exp_nxt;
      r_ack_req <= w_ack;
      if (w_ack)     r_ack_value <= w_ack_val;
      if (w_last_we) r_last_ack  <= i_ack_num;
      if (w_drop && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  // Payload FIFO storage; contents need no reset since the head is gated by count
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {i_payload_data, i_payload_len};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_payload_valid = !w_empty;
  assign o_payload_data  = w_empty ? 32'd0 : r_mem[r_rd_ptr][34:3];
  assign o_payload_len   = w_empty ? 3'd0  : r_mem[r_rd_ptr][2:0];
  assign o_ack_req       = r_ack_req;
  assign o_ack_value     = r_ack_value;
  assign o_last_ack      = r_last_ack;
  assign o_conn_state    = r_state;
  assign o_drop_cnt      = r_drop_cnt;

endmodule
